vga_scan_driver: RTL and testbench
==================================

Name: vga_scan_driver

Overview:
Produces the display side of the pixel interface consumed by the game logic. It scans 640x480@60 Hz with a 25.175 MHz pixel clock and presents pixel_x/pixel_y to the game block. It samples the game block's combinational 8-bit RRRGGGBB colour, then drives the board VGA DAC, sync pins and blank pins. It also generates the once-per-frame game tick that advances the game state machine.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk_pixel  in  1  pixel clock, 25.175 MHz
reset_n  in  1  asynchronous active-low reset
color_in  in  8  RRRGGGBB colour from game logic for the current pixel_x/pixel_y
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1
video_on  out  1  combinational; 1 when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
frame_tick  out  1  one-clk_pixel pulse per frame; game clock enable
vga_r  out  8  red DAC value
vga_g  out  8  green DAC value
vga_b  out  8  blue DAC value
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low
vga_blank_n  out  1  DAC blank, active low
vga_sync_n  out  1  DAC sync-on-green, tied 0
vga_clk  out  1  DAC clock, equals clk_pixel

Behaviour:
- Interface decision: one clock, clk_pixel; reset is asynchronous and active-low, port reset_n. Every register clears immediately on reset_n=0, independent of the clock.
- Derived totals: H_TOTAL = 800, V_TOTAL = 525.
- Horizontal counter h_cnt:
  - increments every clock;
  - wraps from H_TOTAL-1 to 0.
- Vertical counter v_cnt:
  - increments only in the cycle where h_cnt wraps;
  - wraps from V_TOTAL-1 to 0 on that same cycle.
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the registers with no pipeline.
- Output stage is one registered stage. At each clk_pixel edge, the following are computed from the pre-edge counts (h,v):
  - vga_hs <= ~(h >= H_ACTIVE+H_FP && h < H_ACTIVE+H_FP+H_SYNC), i.e. low for h = 656..751;
  - vga_vs <= ~(v >= V_ACTIVE+V_FP && v < V_ACTIVE+V_FP+V_SYNC), i.e. low for v = 490..491;
  - vga_blank_n <= video_on(h,v);
  - RGB <= expand(color_in) when video_on(h,v), else 0.
- Net effect: latency is exactly 1 clock from a pixel_x/pixel_y value to its RGB, sync and blank on the pins. All pin outputs stay mutually aligned.
- Colour expansion (bit replication, no arithmetic):
  - R = {r2,r1,r0,r2,r1,r0,r2,r1};
  - G = same pattern from g2..g0;
  - B = {b1,b0,b1,b0,b1,b0,b1,b0}.
  - Results: 000→0x00, 111→0xFF, 11→0xFF.
- frame_tick is registered.
  - Goes high for exactly one clock on the edge after the counters equal (h=0, v=V_ACTIVE), i.e. at the start of vertical blank.
  - Exactly one pulse per 420000 clocks.
  - The game logic updates on this tick, so it never changes state mid visible frame.
- Reset values:
  - h_cnt = 0, v_cnt = 0, so pixel_x = 0 and pixel_y = 0;
  - vga_r/g/b = 0;
  - vga_hs = 1, vga_vs = 1;
  - vga_blank_n = 0;
  - frame_tick = 0.
  - After release, the first rising edge advances h_cnt to 1.
- Reset asserted mid-frame: outputs return to their reset values immediately. The scan restarts at (0,0) after release, with no partial frame_tick.
- color_in is ignored, and RGB forced to 0, whenever blanked, including porches and sync. No X on color_in may propagate to the pins during blanking.
- Boundaries:
  - h=639 → active, h=640 → blanked;
  - v=479 → active, v=480 → blanked;
  - at h=799,v=524 the next count is (0,0).

Decomposition:
- Shared package vga_pkg holds:
  - the eight timing constants and the derived H_TOTAL and V_TOTAL;
  - the RRRGGGBB colour-field bit positions;
  - the expand-to-24-bit function, shared by any on-screen debug overlay.
- One sub-module, vga_scan_counter, contains the h/v counters, wrap logic and video_on. The top level holds the output register stage and frame_tick.

Test Plan:
- Reset: hold reset_n=0 for 10 clocks with color_in=0xFF. Pins must be hs=1, vs=1, blank_n=0, rgb=0, pixel_x=0, pixel_y=0, frame_tick=0.
- Line timing: run one line and measure vga_hs. It must be low for exactly 96 clocks, falling 1 clock after pixel_x=656. Line period must be 800 clocks. blank_n must be high for exactly 640 clocks per visible line.
- Frame timing: run 2 frames.
  - vga_vs must be low for exactly 1600 clocks (2 lines).
  - frame_tick must pulse once per 420000 clocks, one clock after (0,480).
  - pixel_y must wrap 524→0 on the same edge pixel_x wraps 799→0.
- Colour path and latency:
  - drive color_in=0xE0 only while pixel_x=100,pixel_y=50 → vga_r=0xFF, g=0, b=0 on the next clock only;
  - color_in=0x1C → g=0xFF;
  - color_in=0x03 → b=0xFF;
  - color_in=0x92 (R=100,G=100,B=10) → r=0x92, g=0x92, b=0xAA.
- Blanking: color_in=0xFF constant. rgb must be 0 at pixel_x=640..799 and for all pixel_y≥480, and 0xFF at (639,479).
- Mid-frame reset: assert reset_n at (300,200) for 3 clocks and release. Outputs go to reset values asynchronously, the scan restarts at (0,0), and the next frame_tick arrives 384001 clocks after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, RRRGGGBB field positions and 8-to-24-bit colour expansion
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;
  // Bit replication keeps full-scale codes at 0xFF and zero at 0x00 without arithmetic.
  function automatic rgb24_t expand(input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    rgb24_t o;
    r = c[R_MSB:R_LSB];
    g = c[G_MSB:G_LSB];
    b = c[B_MSB:B_LSB];
    o.r = {r, r, r[2:1]};
    o.g = {g, g, g[2:1]};
    o.b = {4{b}};
    return o;
  endfunction
endpackage

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: horizontal/vertical scan counters with wrap and video_on
//   clk_pixel, reset_n (async active-low) -> h_cnt, v_cnt (0..total-1), video_on (comb)
module vga_scan_counter #(
  parameter int HA = 640,
  parameter int HT = 800,
  parameter int VA = 480,
  parameter int VT = 525
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       video_on
);
  logic h_wrap;
  logic v_wrap;
  assign h_wrap   = h_cnt == 10'(HT - 1);
  assign v_wrap   = v_cnt == 10'(VT - 1);
  assign video_on = h_cnt < 10'(HA) && v_cnt < 10'(VA);
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
    end
endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA scan, registered pin stage and per-frame game tick
//   in : clk_pixel, reset_n (async active-low), color_in[7:0] RRRGGGBB
//   out: pixel_x/pixel_y scan position, video_on, frame_tick,
//        vga_r/g/b, vga_hs/vga_vs (active low), vga_blank_n, vga_sync_n (0), vga_clk
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int HA = H_ACTIVE,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VA = V_ACTIVE,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [7:0] color_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_tick,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);
  rgb24_t px;
  logic   hs_win;
  logic   vs_win;
  vga_scan_counter #(.HA(HA), .HT(HA + HF + HS + HB), .VA(VA), .VT(VA + VF + VS + VB)) u_cnt (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .h_cnt    (pixel_x),
    .v_cnt    (pixel_y),
    .video_on (video_on)
  );
  assign px         = expand(color_in);
  assign hs_win     = pixel_x >= 10'(HA + HF) && pixel_x < 10'(HA + HF + HS);
  assign vs_win     = pixel_y >= 10'(VA + VF) && pixel_y < 10'(VA + VF + VS);
  assign vga_sync_n = 1'b0;
  assign vga_clk    = clk_pixel;
  // All pins register from the same pre-edge count so they stay aligned one clock behind pixel_x/pixel_y.
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      vga_r       <= video_on ? px.r : '0;
      vga_g       <= video_on ? px.g : '0;
      vga_b       <= video_on ? px.b : '0;
      vga_hs      <= !hs_win;
      vga_vs      <= !vs_win;
      vga_blank_n <= video_on;
      frame_tick  <= pixel_x == '0 && pixel_y == 10'(VA);
    end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: random-colour scan check of full-size and shrunk-timing drivers against a cycle-count model
module tb_vga_scan_driver;
  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       von;
    logic       tick;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bn;
  } obs_t;
  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [7:0] color_in;
  logic [7:0] col_q;
  int         t;
  int         errors = 0;
  int         checks = 0;
  int         hs_low10 = 0;
  int         bn_hi10 = 0;
  int         vs_lows = 0;
  int         ticks = 0;
  int         first_tick = -1;
  int         last_tick = 0;
  logic [7:0] tbl [5] = '{8'hE0, 8'h1C, 8'h03, 8'h92, 8'h00};
  logic [9:0] fr_px, fr_py, sm_px, sm_py;
  logic       fr_von, fr_tick, fr_hs, fr_vs, fr_bn, fr_sn, fr_ck;
  logic       sm_von, sm_tick, sm_hs, sm_vs, sm_bn, sm_sn, sm_ck;
  logic [7:0] fr_r, fr_g, fr_b, sm_r, sm_g, sm_b;
  always #20 clk_pixel = ~clk_pixel;
  vga_scan_driver u_full (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .color_in(color_in),
    .pixel_x(fr_px), .pixel_y(fr_py), .video_on(fr_von), .frame_tick(fr_tick),
    .vga_r(fr_r), .vga_g(fr_g), .vga_b(fr_b), .vga_hs(fr_hs), .vga_vs(fr_vs),
    .vga_blank_n(fr_bn), .vga_sync_n(fr_sn), .vga_clk(fr_ck)
  );
  vga_scan_driver #(.HA(8), .HF(2), .HS(3), .HB(2), .VA(6), .VF(1), .VS(2), .VB(1)) u_small (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .color_in(color_in),
    .pixel_x(sm_px), .pixel_y(sm_py), .video_on(sm_von), .frame_tick(sm_tick),
    .vga_r(sm_r), .vga_g(sm_g), .vga_b(sm_b), .vga_hs(sm_hs), .vga_vs(sm_vs),
    .vga_blank_n(sm_bn), .vga_sync_n(sm_sn), .vga_clk(sm_ck)
  );
  // Expected outputs after tt edges since release; pins reflect the scan position one edge earlier.
  function automatic obs_t model(input int ha, hf, hs, hb, va, vf, vs, vb, tt, input logic [7:0] c);
    int ht, vt, ph, pv;
    logic vis;
    obs_t o;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    o.px = 10'(tt % ht);
    o.py = 10'((tt / ht) % vt);
    o.von = (tt % ht) < ha && ((tt / ht) % vt) < va;
    if (tt == 0) begin
      o.tick = 1'b0;
      o.r = 8'h00;
      o.g = 8'h00;
      o.b = 8'h00;
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.bn = 1'b0;
      return o;
    end
    ph = (tt - 1) % ht;
    pv = ((tt - 1) / ht) % vt;
    vis = ph < ha && pv < va;
    o.bn = vis;
    o.hs = !(ph >= ha + hf && ph < ha + hf + hs);
    o.vs = !(pv >= va + vf && pv < va + vf + vs);
    o.tick = (tt - 1) % (ht * vt) == va * ht;
    o.r = vis ? 8'((int'(c[7:5]) * 73) >> 1) : 8'h00;
    o.g = vis ? 8'((int'(c[4:2]) * 73) >> 1) : 8'h00;
    o.b = vis ? 8'(int'(c[1:0]) * 85) : 8'h00;
    return o;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
    end
  endtask
  task automatic check_all();
    obs_t ef, es;
    ef = model(640, 16, 96, 48, 480, 10, 2, 33, t, col_q);
    es = model(8, 2, 3, 2, 6, 1, 2, 1, t, col_q);
    chk("full_pins", {fr_px, fr_py, fr_von, fr_tick, fr_r, fr_g, fr_b, fr_hs, fr_vs, fr_bn}, ef);
    chk("small_pins", {sm_px, sm_py, sm_von, sm_tick, sm_r, sm_g, sm_b, sm_hs, sm_vs, sm_bn}, es);
    chk("sync_clk", {fr_sn, fr_ck, sm_sn, sm_ck}, 4'b0000);
    if (t == 40101) chk("col_red", {fr_r, fr_g, fr_b}, 24'hFF0000);
    if (t == 40102) chk("col_green", {fr_r, fr_g, fr_b}, 24'h00FF00);
    if (t == 40103) chk("col_blue", {fr_r, fr_g, fr_b}, 24'h0000FF);
    if (t == 40104) chk("col_mix", {fr_r, fr_g, fr_b}, 24'h9292AA);
    if (t == 40105) chk("col_one_clk", {fr_r, fr_g, fr_b}, 24'h000000);
    if (t > 8000 && t <= 8800) begin
      hs_low10 += int'(!fr_hs);
      bn_hi10 += int'(fr_bn);
    end
    if (t >= 1 && t <= 1500) begin
      vs_lows += int'(!sm_vs);
      ticks += int'(sm_tick);
    end
    if (sm_tick && reset_n) begin
      if (first_tick < 0) first_tick = t;
      if (last_tick > 0) chk("tick_period", 64'(t - last_tick), 64'd150);
      last_tick = t;
    end
  endtask
  task automatic step();
    int h, v, sh, sv;
    @(posedge clk_pixel);
    col_q = color_in;
    if (reset_n) t++;
    @(negedge clk_pixel);
    check_all();
    h = t % 800;
    v = (t / 800) % 525;
    sh = t % 15;
    sv = (t / 15) % 10;
    color_in = 8'($urandom);
    if (v == 50 && h >= 100 && h <= 104) color_in = tbl[h-100];
    else if (h >= 640 && !(sh < 8 && sv < 6)) color_in = 'x;
  endtask
  initial begin
    reset_n = 1'b0;
    color_in = 8'hFF;
    col_q = 8'hFF;
    t = 0;
    repeat (10) step();
    chk("rst_pins", {fr_hs, fr_vs, fr_bn, fr_tick, fr_r, fr_g, fr_b, fr_px, fr_py}, {4'b1100, 24'h0, 20'h0});
    reset_n = 1'b1;
    while (t < 48049) step();
    chk("hs_low_line", 64'(hs_low10), 64'd96);
    chk("blank_hi_line", 64'(bn_hi10), 64'd640);
    chk("vs_low_10frames", 64'(vs_lows), 64'd300);
    chk("ticks_10frames", 64'(ticks), 64'd10);
    chk("first_tick", 64'(first_tick), 64'd91);
    #5 reset_n = 1'b0;
    t = 0;
    last_tick = 0;
    first_tick = -1;
    #1 check_all();
    chk("async_rst", {fr_hs, fr_vs, fr_bn, fr_r, fr_px, fr_py, sm_px, sm_py}, {3'b110, 8'h0, 40'h0});
    repeat (3) step();
    reset_n = 1'b1;
    repeat (200) step();
    chk("tick_after_rst", 64'(first_tick), 64'd91);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
